// File: rtl/sqrt_fp_feeder.sv
// Valid/ready stream front-end for the iterative fixed-point sqrt core: a DEPTH-entry radicand FIFO, one core run per entry, results held until taken.
// Optional build macro SQRT_FEEDER_ROUND_EN rounds the root to nearest; without it the core's truncated root passes through.
module sqrt_fp_feeder #(
  parameter int WIDTH = 32,
  parameter int FBITS = 10,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_root,
  output logic [WIDTH-1:0]         out_rem,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     sq_start,
  output logic [WIDTH-1:0]         sq_rad,
  input  logic                     sq_busy,
  input  logic                     sq_valid,
  input  logic [WIDTH-1:0]         sq_root,
  input  logic [WIDTH-1:0]         sq_rem
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || FBITS < 0 || FBITS >= WIDTH) begin : g_param_check
    $error("sqrt_fp_feeder: DEPTH must be a power of two >= 2 and 0 <= FBITS < WIDTH");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic [WIDTH-1:0] sq_rad_q, sq_rad_d;
  logic [WIDTH-1:0] root_q, root_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] root_cap;
  logic             full, empty, push, pop;

  assign full  = (level_q == LW'(DEPTH));
  assign empty = (level_q == '0);
  // A full FIFO refuses the push even when the controller pops the same cycle.
  assign push  = in_valid && !full;
  assign pop   = (state_q == S_IDLE) && !empty;

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

`ifdef SQRT_FEEDER_ROUND_EN
  always_comb begin
    root_cap = sq_root;
    if (sq_rem > sq_root && sq_root != '1) begin
      root_cap = sq_root + 1'b1;
    end
  end
`else
  assign root_cap = sq_root;
`endif

  always_comb begin
    state_d     = state_q;
    sq_rad_d    = sq_rad_q;
    root_d      = root_q;
    rem_d       = rem_q;
    out_valid_d = out_valid_q;
    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          sq_rad_d = mem_q[rd_ptr_q];
          state_d  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // The core drops valid on the edge that samples start, so this never sees a stale result.
        if (sq_valid && !sq_busy) begin
          root_d      = root_cap;
          rem_d       = sq_rem;
          out_valid_d = 1'b1;
          state_d     = S_HOLD;
        end
      end
      S_HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      sq_rad_q    <= '0;
      root_q      <= '0;
      rem_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      sq_rad_q    <= sq_rad_d;
      root_q      <= root_d;
      rem_q       <= rem_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready   = !full;
  assign fifo_level = level_q;
  assign sq_start   = (state_q == S_ISSUE);
  assign sq_rad     = sq_rad_q;
  assign out_valid  = out_valid_q;
  assign out_root   = root_q;
  assign out_rem    = rem_q;

endmodule

// File: tb/tb_sqrt_fp_feeder.sv
// Bench for sqrt_fp_feeder: behavioural sqrt core, queue scoreboard fed at input handshakes, monitor popping at output handshakes.
// Honours SQRT_FEEDER_ROUND_EN when the same macro is defined for the whole build.
module tb_sqrt_fp_feeder;

  localparam int W    = 32;
  localparam int F    = 10;
  localparam int D    = 4;
  localparam int ITER = (W + F) >> 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_data = '0;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_root, out_rem;
  logic [2:0]    fifo_level;
  logic          sq_start;
  logic [W-1:0]  sq_rad;
  logic          sq_busy = 1'b0;
  logic          sq_valid = 1'b0;
  logic [W-1:0]  sq_root = '0;
  logic [W-1:0]  sq_rem = '0;

  logic          rdy_force = 1'b1;
  logic          rdy_main = 1'b0;
  logic          rdy_rand = 1'b1;
  assign out_ready = rdy_force ? rdy_main : rdy_rand;

  int n_cmp = 0;
  int n_fail = 0;
  int n_out = 0;
  int cyc = 0;
  int acc_cyc = 0, issue_cyc = 0, rise_cyc = 0, rise_gap = 0;

  logic [W-1:0] drv_root = '0, drv_rem = '0;
  logic [2*W-1:0] exp_q[$];

  sqrt_fp_feeder #(.WIDTH(W), .FBITS(F), .DEPTH(D)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_root(out_root), .out_rem(out_rem),
    .fifo_level(fifo_level),
    .sq_start(sq_start), .sq_rad(sq_rad), .sq_busy(sq_busy), .sq_valid(sq_valid),
    .sq_root(sq_root), .sq_rem(sq_rem)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    #1;
    rdy_rand = ($urandom_range(0, 3) != 0);
  end

  // Largest r with r*r <= x, found bit by bit.
  function automatic logic [63:0] isqrt(input logic [63:0] x);
    logic [63:0] r, t;
    r = '0;
    for (int b = 31; b >= 0; b--) begin
      t = r | (64'd1 << b);
      if (t * t <= x) r = t;
    end
    return r;
  endfunction

  function automatic logic [W-1:0] ref_root(input logic [W-1:0] d);
    logic [63:0] r;
    r = isqrt({32'b0, d} << F);
    return r[W-1:0];
  endfunction

  function automatic logic [W-1:0] ref_rem(input logic [W-1:0] d);
    logic [63:0] x, r, m;
    x = {32'b0, d} << F;
    r = isqrt(x);
    m = x - r * r;
    return m[W-1:0];
  endfunction

  // Nearest root: round up when sqrt(x) > r + 1/2, i.e. 4x > (2r+1)^2.
  function automatic logic [W-1:0] rnd(input logic [W-1:0] d, input logic [W-1:0] r);
    logic [63:0] x, t;
    bit en;
`ifdef SQRT_FEEDER_ROUND_EN
    en = 1'b1;
`else
    en = 1'b0;
`endif
    x = {32'b0, d} << F;
    t = 2 * {32'b0, r} + 64'd1;
    if (en && (4 * x > t * t) && r != {W{1'b1}}) return r + 1'b1;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Behavioural core: busy for ITER cycles after start, then valid with root/rem; start always restarts it.
  int core_cnt = 0;
  logic [W-1:0] core_rad = '0;
  always @(posedge clk) begin
    if (sq_start) begin
      sq_busy  <= 1'b1;
      sq_valid <= 1'b0;
      core_cnt <= ITER;
      core_rad <= sq_rad;
      sq_root  <= $urandom;
      sq_rem   <= $urandom;
    end else if (sq_busy) begin
      core_cnt <= core_cnt - 1;
      if (core_cnt == 1) begin
        sq_busy  <= 1'b0;
        sq_valid <= 1'b1;
        sq_root  <= ref_root(core_rad);
        sq_rem   <= ref_rem(core_rad);
      end
    end
  end

  logic         ov_prev = 1'b0, hold_prev = 1'b0;
  logic [W-1:0] held_root = '0, held_rem = '0;
  always @(negedge clk) begin
    logic [2*W-1:0] e;
    if (rst) begin
      exp_q.delete();
      hold_prev = 1'b0;
    end else begin
      if (in_valid && in_ready) begin
        exp_q.push_back({drv_root, drv_rem});
        acc_cyc = cyc + 1;
      end
      if (sq_start) issue_cyc = cyc + 1;
      if (out_valid && !ov_prev) begin
        rise_gap = cyc - rise_cyc;
        rise_cyc = cyc;
      end
      if (hold_prev) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_root", out_root, held_root);
        chk("hold_rem", out_rem, held_rem);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_output", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("out_root", out_root, e[2*W-1:W]);
          chk("out_rem", out_rem, e[W-1:0]);
          n_out++;
        end
      end
      hold_prev = out_valid && !out_ready;
      held_root = out_root;
      held_rem  = out_rem;
    end
    ov_prev = out_valid;
  end

  task automatic send(input logic [W-1:0] d, input logic [W-1:0] r, input logic [W-1:0] m,
                      input int bound, output bit ok);
    drv_root = rnd(d, r);
    drv_rem  = m;
    in_data  = d;
    in_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      if (ok) break;
    end
    in_valid = 1'b0;
  endtask

  task automatic send_chk(input logic [W-1:0] d, input logic [W-1:0] r, input logic [W-1:0] m);
    bit ok;
    send(d, r, m, 500, ok);
    if (!ok) chk("send_timeout", 0, 1);
  endtask

  task automatic send_rand(input logic [W-1:0] d);
    send_chk(d, ref_root(d), ref_rem(d));
  endtask

  task automatic drain(input int bound);
    bit done;
    done = 1'b0;
    for (int i = 0; i < bound && !done; i++) begin
      @(negedge clk);
      done = (exp_q.size() == 0) && !out_valid;
    end
    if (!done) chk("drain_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int n0;
    logic [W-1:0] d;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_root", out_root, 0);
    chk("rst_out_rem", out_rem, 0);
    chk("rst_fifo_level", fifo_level, 0);
    chk("rst_sq_start", sq_start, 0);
    chk("rst_sq_rad", sq_rad, 0);
    rst = 1'b0;
    rdy_main = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    send_chk(32'd4096, 32'd2048, 32'd0);
    drain(200);
    chk("latency", rise_cyc - acc_cyc, ITER + 3);

    send_chk(32'd2048, 32'd1448, 32'd448);
    send_chk(32'd3072, 32'd1773, 32'd2199);
    send_chk(32'd0, 32'd0, 32'd0);
    send_chk(32'hFFFF_FFFF, 32'd2097151, 32'd4193279);
    drain(400);
    chk("throughput", rise_gap, ITER + 4);

    // Output stalled: one job parks in HOLD, four fill the FIFO, the sixth is refused.
    rdy_main = 1'b0;
    n0 = n_out;
    for (int i = 0; i < 5; i++) begin
      d = $urandom;
      send(d, ref_root(d), ref_rem(d), 3, ok);
      chk("bp_accept", ok, 1);
    end
    d = $urandom;
    send(d, ref_root(d), ref_rem(d), 30, ok);
    chk("bp_sixth_refused", ok, 0);
    chk("bp_level", fifo_level, 4);
    chk("bp_in_ready", in_ready, 0);
    chk("bp_out_valid", out_valid, 1);
    rdy_main = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready;
    end
    chk("bp_ready_back", ok, 1);
    chk("bp_level_after_pop", fifo_level, 3);
    drain(600);
    chk("bp_count", n_out - n0, 5);

    // Reset during a core run with two radicands queued.
    for (int i = 0; i < 3; i++) send_rand($urandom);
    for (int i = 0; i < 50 && cyc < issue_cyc + 5; i++) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_level", fifo_level, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    n0 = n_out;
    repeat (40) @(posedge clk);
    #1;
    chk("mid_rst_no_output", n_out - n0, 0);
    send_chk(32'd4096, 32'd2048, 32'd0);
    drain(200);
    chk("mid_rst_fresh", n_out - n0, 1);

    // Randomised traffic with random output stalls.
    rdy_force = 1'b0;
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 3))
        0:       d = $urandom;
        1:       d = $urandom_range(0, 65535);
        2:       d = {$urandom_range(0, 31), 10'b0};
        default: d = $urandom | 32'hFFF0_0000;
      endcase
      send_rand(d);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end
    rdy_force = 1'b1;
    rdy_main = 1'b1;
    drain(2000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
